// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the data-memory port, extracts load data and registers MEM/WB.
// Optional misalignment trapping is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_alu_out_in,
  input  logic [31:0] mem_rv1_in,
  input  logic [31:0] mem_pc_imm_in,
  input  logic [31:0] mem_imm_in,
  input  logic [4:0]  mem_rd_in,
  input  logic [1:0]  mem_reg_in_sel_in,
  input  logic [3:0]  mem_dwe_in,
  input  logic [2:0]  mem_func3_in,
  input  logic        mem_mem_reg_in,
  input  logic        mem_reg_wr_in,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        bus_err,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_wr
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap,
  output logic [31:0] misalign_addr
`endif
);

  typedef enum logic [0:0] {IDLE, WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic               busErr_q;
  logic [31:0]        wbData_q;
  logic [4:0]         wbRd_q;
  logic               wbRegWr_q;

  logic               memOp;
  logic               opEff;
  logic               misaligned;
  logic               timeoutHit;
  logic [1:0]         addrLo;
  logic [7:0]         loadByte;
  logic [15:0]        loadHalf;
  logic [31:0]        loadData;
  logic [31:0]        selData;
  logic [31:0]        wbNext;

  assign addrLo = mem_alu_out_in[1:0];
  assign memOp  = mem_mem_reg_in | (|mem_dwe_in);

`ifdef MEM_MISALIGN_TRAP_EN
  logic        trap_q;
  logic [31:0] trapAddr_q;
  logic        loadMis;
  logic        storeMis;

  // Halfword accesses need bit 0 clear, word accesses need both low bits clear.
  always_comb begin
    loadMis = 1'b0;
    if (mem_mem_reg_in) begin
      case (mem_func3_in)
        3'b001, 3'b101: loadMis = addrLo[0];
        3'b010:         loadMis = |addrLo;
        default:        loadMis = 1'b0;
      endcase
    end
  end

  always_comb begin
    storeMis = 1'b0;
    case (mem_dwe_in)
      4'b0011: storeMis = addrLo[0];
      4'b1111: storeMis = |addrLo;
      default: storeMis = 1'b0;
    endcase
  end

  assign misaligned    = loadMis | storeMis;
  assign misalign_trap = trap_q;
  assign misalign_addr = trapAddr_q;
`else
  assign misaligned = 1'b0;
`endif

  assign opEff = memOp & ~misaligned;

  // Memory port is purely combinational off the held EX/MEM bundle.
  assign dmem_req  = opEff;
  assign dmem_addr = {mem_alu_out_in[31:2], 2'b00};

  always_comb begin
    dmem_we = 4'b0000;
    if (opEff) dmem_we = mem_dwe_in << addrLo;
  end

  always_comb begin
    case (mem_dwe_in)
      4'b0001: dmem_wdata = {4{mem_rv1_in[7:0]}};
      4'b0011: dmem_wdata = {2{mem_rv1_in[15:0]}};
      default: dmem_wdata = mem_rv1_in;
    endcase
  end

  always_comb begin
    case (addrLo)
      2'd0:    loadByte = dmem_rdata[7:0];
      2'd1:    loadByte = dmem_rdata[15:8];
      2'd2:    loadByte = dmem_rdata[23:16];
      default: loadByte = dmem_rdata[31:24];
    endcase
    loadHalf = addrLo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  end

  always_comb begin
    case (mem_func3_in)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b100:  loadData = {24'h0, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b101:  loadData = {16'h0, loadHalf};
      default: loadData = dmem_rdata;
    endcase
  end

  always_comb begin
    case (mem_reg_in_sel_in)
      2'b01:   selData = mem_imm_in;
      2'b10:   selData = mem_pc_imm_in;
      default: selData = mem_alu_out_in;
    endcase
  end

  assign wbNext = mem_mem_reg_in ? loadData : selData;

  // FSM state and wait-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // A late ready in the final WAIT cycle takes priority over the timeout.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      IDLE: begin
        if (opEff && !dmem_ready) begin
          state_d   = WAIT;
          waitCnt_d = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!opEff || dmem_ready || (waitCnt_q == CNT_W'(TIMEOUT))) begin
          state_d   = IDLE;
          waitCnt_d = '0;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        waitCnt_d = '0;
      end
    endcase
  end

  always_comb begin
    timeoutHit = (state_q == WAIT) && (waitCnt_q == CNT_W'(TIMEOUT)) && !dmem_ready;
    mem_stall  = opEff & ~dmem_ready & ~timeoutHit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busErr_q <= 1'b0;
    end else if (timeoutHit) begin
      busErr_q <= 1'b1;
    end
  end

  // MEM/WB boundary: stalls and aborted or trapped accesses become bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbData_q  <= '0;
      wbRd_q    <= '0;
      wbRegWr_q <= 1'b0;
    end else if (mem_stall || timeoutHit || misaligned) begin
      wbRegWr_q <= 1'b0;
    end else begin
      wbData_q  <= wbNext;
      wbRd_q    <= mem_rd_in;
      wbRegWr_q <= mem_reg_wr_in;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q     <= 1'b0;
      trapAddr_q <= '0;
    end else begin
      trap_q <= misaligned;
      if (misaligned) trapAddr_q <= mem_alu_out_in;
    end
  end
`endif

  assign bus_err   = busErr_q;
  assign wb_data   = wbData_q;
  assign wb_rd     = wbRd_q;
  assign wb_reg_wr = wbRegWr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, wait/timeout/reset sequences,
// and randomized operations checked against a byte-level reference model.
module tb_mem_access_stage;

  localparam int TO = 4;

  typedef struct {
    logic        isLoad;
    logic [2:0]  f3;
    logic [3:0]  dwe;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] rv1;
    logic [31:0] rdata;
    logic [31:0] pcImm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        regWr;
    logic [3:0]  expWe;
    logic [31:0] expWdata;
    logic [31:0] expWb;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_alu_out_in, mem_rv1_in, mem_pc_imm_in, mem_imm_in;
  logic [4:0]  mem_rd_in;
  logic [1:0]  mem_reg_in_sel_in;
  logic [3:0]  mem_dwe_in;
  logic [2:0]  mem_func3_in;
  logic        mem_mem_reg_in, mem_reg_wr_in;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall, bus_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_wr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] misalign_addr;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expWbHeld = '0;
  logic        expBusErr = 1'b0;
  vec_t        tbl[15];

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .mem_alu_out_in(mem_alu_out_in), .mem_rv1_in(mem_rv1_in),
    .mem_pc_imm_in(mem_pc_imm_in), .mem_imm_in(mem_imm_in),
    .mem_rd_in(mem_rd_in), .mem_reg_in_sel_in(mem_reg_in_sel_in),
    .mem_dwe_in(mem_dwe_in), .mem_func3_in(mem_func3_in),
    .mem_mem_reg_in(mem_mem_reg_in), .mem_reg_wr_in(mem_reg_wr_in),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall), .bus_err(bus_err),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap), .misalign_addr(misalign_addr)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic isLoad, input logic [2:0] f3, input logic [3:0] dwe,
                                 input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] rv1,
                                 input logic [31:0] rdata, input logic [4:0] rd, input logic regWr,
                                 input logic [3:0] expWe, input logic [31:0] expWdata,
                                 input logic [31:0] expWb);
    vec_t v;
    v.isLoad = isLoad; v.f3 = f3; v.dwe = dwe; v.sel = sel; v.addr = addr; v.rv1 = rv1;
    v.rdata = rdata; v.pcImm = 32'h0000_0400; v.imm = 32'h0000_0ABC; v.rd = rd; v.regWr = regWr;
    v.expWe = expWe; v.expWdata = expWdata; v.expWb = expWb;
    return v;
  endfunction

  // Reference model: byte-lane view of the access, independent of any shift/mux structure.
  function automatic vec_t modelFill(input vec_t vin);
    vec_t        v;
    int          a, size;
    logic [31:0] b, h, ld, sv;
    v = vin;
    a = int'(v.addr[1:0]);
    size = (v.dwe == 4'b0001) ? 1 : (v.dwe == 4'b0011) ? 2 : 4;
    v.expWe = '0;
    v.expWdata = '0;
    if (v.dwe != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        v.expWe[i] = (i >= a) && (i < a + size);
        v.expWdata[8*i +: 8] = v.rv1[8*(i % size) +: 8];
      end
    end
    b = (v.rdata >> (8 * a)) & 32'hFF;
    h = (v.rdata >> (16 * (a / 2))) & 32'hFFFF;
    case (v.f3)
      3'd0:    ld = (b >= 128) ? b - 32'd256 : b;
      3'd4:    ld = b;
      3'd1:    ld = (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    ld = h;
      default: ld = v.rdata;
    endcase
    sv = (v.sel == 2'd1) ? v.imm : (v.sel == 2'd2) ? v.pcImm : v.addr;
    v.expWb = v.isLoad ? ld : sv;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    mem_alu_out_in    = v.addr;
    mem_rv1_in        = v.rv1;
    mem_pc_imm_in     = v.pcImm;
    mem_imm_in        = v.imm;
    mem_rd_in         = v.rd;
    mem_reg_in_sel_in = v.sel;
    mem_dwe_in        = v.dwe;
    mem_func3_in      = v.f3;
    mem_mem_reg_in    = v.isLoad;
    mem_reg_wr_in     = v.regWr;
    dmem_rdata        = v.rdata;
  endtask

  // Ready arrives in cycle k (k > TO means never); expected stall count follows from k alone.
  task automatic runOp(input vec_t v, input int k, input string tag);
    logic op, timedOut;
    int   last;
    op = v.isLoad | (|v.dwe);
    timedOut = op && (k > TO);
    last = !op ? 0 : (timedOut ? TO : k);
    applyStimulus(v);
    for (int c = 0; c <= last; c++) begin
      dmem_ready = op ? (c == k) : 1'($urandom_range(0, 1));
      #1;
      checkOutput({tag, ".req"}, dmem_req, op);
      checkOutput({tag, ".stall"}, mem_stall, c < last);
      checkOutput({tag, ".addr"}, dmem_addr, {v.addr[31:2], 2'b00});
      checkOutput({tag, ".we"}, dmem_we, v.expWe);
      if (v.dwe != 4'b0000) checkOutput({tag, ".wdata"}, dmem_wdata, v.expWdata);
      @(posedge clk);
      #1;
      if (c < last) begin
        checkOutput({tag, ".bubbleWr"}, wb_reg_wr, 1'b0);
        checkOutput({tag, ".bubbleData"}, wb_data, expWbHeld);
      end
    end
    if (timedOut) begin
      expBusErr = 1'b1;
      checkOutput({tag, ".abortWr"}, wb_reg_wr, 1'b0);
      checkOutput({tag, ".abortData"}, wb_data, expWbHeld);
    end else begin
      checkOutput({tag, ".wbWr"}, wb_reg_wr, v.regWr);
      checkOutput({tag, ".wbRd"}, wb_rd, v.rd);
      checkOutput({tag, ".wbData"}, wb_data, v.expWb);
      expWbHeld = v.expWb;
    end
    checkOutput({tag, ".busErr"}, bus_err, expBusErr);
    dmem_ready = 1'b0;
  endtask

  initial begin
    vec_t nop, rv;
    logic [3:0] dweSet[3];
    dweSet[0] = 4'b0001; dweSet[1] = 4'b0011; dweSet[2] = 4'b1111;
    nop = mkVec(0, 3'd0, 4'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 4'h0, 32'h0, 32'h0);

    tbl[0]  = mkVec(1, 3'b010, 4'h0, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd1, 1, 4'h0, 32'h0, 32'hDEADBEEF);
    tbl[1]  = mkVec(1, 3'b000, 4'h0, 2'd0, 32'h103, 32'h0, 32'h80FF0000, 5'd2, 1, 4'h0, 32'h0, 32'hFFFFFF80);
    tbl[2]  = mkVec(1, 3'b100, 4'h0, 2'd0, 32'h103, 32'h0, 32'h80FF0000, 5'd3, 1, 4'h0, 32'h0, 32'h00000080);
    tbl[3]  = mkVec(1, 3'b001, 4'h0, 2'd0, 32'h102, 32'h0, 32'h80FF0000, 5'd4, 1, 4'h0, 32'h0, 32'hFFFF80FF);
    tbl[4]  = mkVec(1, 3'b101, 4'h0, 2'd0, 32'h102, 32'h0, 32'h80FF0000, 5'd5, 1, 4'h0, 32'h0, 32'h000080FF);
    tbl[5]  = mkVec(1, 3'b000, 4'h0, 2'd0, 32'h101, 32'h0, 32'h00007F00, 5'd6, 1, 4'h0, 32'h0, 32'h0000007F);
    tbl[6]  = mkVec(0, 3'b000, 4'h1, 2'd0, 32'h202, 32'h12345678, 32'h0, 5'd0, 0, 4'b0100, 32'h78787878, 32'h202);
    tbl[7]  = mkVec(0, 3'b001, 4'h3, 2'd0, 32'h202, 32'h12345678, 32'h0, 5'd0, 0, 4'b1100, 32'h56785678, 32'h202);
    tbl[8]  = mkVec(0, 3'b010, 4'hF, 2'd0, 32'h200, 32'h12345678, 32'h0, 5'd0, 0, 4'b1111, 32'h12345678, 32'h200);
    tbl[9]  = mkVec(0, 3'b010, 4'hF, 2'd0, 32'h203, 32'h12345678, 32'h0, 5'd0, 0, 4'b1000, 32'h12345678, 32'h203);
    tbl[10] = mkVec(0, 3'b000, 4'h0, 2'd2, 32'h55, 32'h0, 32'h0, 5'd7, 1, 4'h0, 32'h0, 32'h400);
    tbl[11] = mkVec(0, 3'b000, 4'h0, 2'd1, 32'h55, 32'h0, 32'h0, 5'd8, 1, 4'h0, 32'h0, 32'hABC);
    tbl[12] = mkVec(0, 3'b000, 4'h0, 2'd3, 32'h1234, 32'h0, 32'h0, 5'd9, 1, 4'h0, 32'h0, 32'h1234);
    tbl[13] = mkVec(0, 3'b000, 4'h0, 2'd0, 32'hCAFE, 32'h0, 32'h0, 5'd10, 0, 4'h0, 32'h0, 32'hCAFE);
    tbl[14] = mkVec(1, 3'b011, 4'h0, 2'd0, 32'h101, 32'h0, 32'h11223344, 5'd11, 1, 4'h0, 32'h0, 32'h11223344);

    reset = 1'b1;
    dmem_ready = 1'b0;
    applyStimulus(nop);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.wbData", wb_data, 32'h0);
    checkOutput("rst.wbRd", wb_rd, 5'd0);
    checkOutput("rst.wbWr", wb_reg_wr, 1'b0);
    checkOutput("rst.busErr", bus_err, 1'b0);
    checkOutput("rst.req", dmem_req, 1'b0);
    checkOutput("rst.stall", mem_stall, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) runOp(tbl[i], 0, $sformatf("vec%0d", i));

    runOp(tbl[6], 2, "sbWait");
    runOp(tbl[0], TO, "readyAtLimit");
    runOp(tbl[0], 99, "timeout");
    runOp(tbl[10], 0, "stickyErr");

    // Abandon a load part-way through WAIT with a reset.
    applyStimulus(tbl[1]);
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midWait.stall", mem_stall, 1'b1);
    reset = 1'b1;
    applyStimulus(nop);
    @(posedge clk);
    #1;
    checkOutput("midRst.wbData", wb_data, 32'h0);
    checkOutput("midRst.wbRd", wb_rd, 5'd0);
    checkOutput("midRst.wbWr", wb_reg_wr, 1'b0);
    checkOutput("midRst.busErr", bus_err, 1'b0);
    checkOutput("midRst.stall", mem_stall, 1'b0);
    reset = 1'b0;
    expWbHeld = '0;
    expBusErr = 1'b0;
    runOp(tbl[0], TO, "postReset");

    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      rv = nop;
      rv.addr  = $urandom;
      rv.rv1   = $urandom;
      rv.rdata = $urandom;
      rv.pcImm = $urandom;
      rv.imm   = $urandom;
      rv.rd    = 5'($urandom_range(0, 31));
      rv.sel   = 2'($urandom_range(0, 3));
      rv.f3    = 3'($urandom_range(0, 7));
      rv.regWr = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        rv.isLoad = 1'b1;
      end else if (kind == 1) begin
        rv.dwe = dweSet[$urandom_range(0, 2)];
        rv.regWr = 1'b0;
      end
      rv = modelFill(rv);
      runOp(rv, $urandom_range(0, TO + 2), $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register. It consumes the registered `mem_*` bundle.
- Drives a req/ready data-memory port with lane-aligned store data and byte enables.
- Extracts and sign/zero-extends load data.
- Registers the selected write-back result into the MEM/WB boundary.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT, 16: max WAIT cycles before a request is aborted (≥1).
- CNT_W, 5: width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_alu_out_in  in  32  effective address, or ALU result.
- mem_rv1_in  in  32  store data, unaligned.
- mem_pc_imm_in  in  32  PC+imm result.
- mem_imm_in  in  32  immediate result.
- mem_rd_in  in  5  destination register.
- mem_reg_in_sel_in  in  2  result select: 00 ALU, 01 IMM, 10 PC+IMM, 11 ALU.
- mem_dwe_in  in  4  unshifted store mask: 0001 SB, 0011 SH, 1111 SW, 0000 no store.
- mem_func3_in  in  3  load type.
- mem_mem_reg_in  in  1  load instruction.
- mem_reg_wr_in  in  1  register write enable.
- dmem_req  out  1  memory request.
- dmem_addr  out  32  word address, i.e. {addr[31:2], 2'b00}.
- dmem_we  out  4  lane byte enables, zero for loads.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read word.
- dmem_ready  in  1  access complete this cycle.
- mem_stall  out  1  freeze PC/IF/ID/EX and EX/MEM.
- bus_err  out  1  sticky timeout flag.
- wb_data  out  32  registered write-back value.
- wb_rd  out  5  registered destination.
- wb_reg_wr  out  1  registered write enable.

Behaviour:
- **Memory op:** `op = mem_mem_reg_in | (|mem_dwe_in)`.
- **Request:** `dmem_req = op` (combinational) in IDLE and WAIT. Address, enables and data derive combinationally from the held EX/MEM inputs, so they are stable while stalled.
- **Store enables:** `dmem_we = mem_dwe_in << addr[1:0]`.
  - SB: `wdata = {4{rv1[7:0]}}`.
  - SH: `wdata = {2{rv1[15:0]}}`.
  - SW: `wdata = rv1`.
  - Misaligned SH/SW: shifted mask truncated to 4 bits; no trap in the base build.
- **Load extraction:** byte lane = `addr[1:0]`, half lane = `addr[1]`.
  - func3 000 LB and 100 LBU: sign-/zero-extended byte.
  - func3 001 LH and 101 LHU: sign-/zero-extended half.
  - func3 010 LW: full word.
  - Other func3 values: full word.
- **Stall:** `mem_stall = op & ~dmem_ready & ~timeout_hit` (combinational).
  - Zero-wait (ready in the same cycle as req) means no stall.
- **FSM states:** IDLE, WAIT.
  - IDLE → WAIT when `op & ~dmem_ready`; the counter loads 1.
  - WAIT with `dmem_ready`: → IDLE.
  - WAIT with counter == TIMEOUT and no ready: `timeout_hit = 1` this cycle → IDLE, and `bus_err` is set.
  - Otherwise, in WAIT: the counter increments.
  - ready and timeout in the same cycle: ready wins and no error is raised.
- **MEM/WB register update (each posedge):**
  - If `mem_stall`: bubble (`wb_reg_wr <= 0`; `wb_data` and `wb_rd` hold).
  - Else if `timeout_hit`: `wb_reg_wr <= 0` (instruction squashed).
  - Else: `wb_rd <= mem_rd_in`, `wb_reg_wr <= mem_reg_wr_in`, `wb_data <=` load data if `mem_mem_reg_in`, otherwise the sel-mux result.
- **Reset:** `state` = IDLE, counter 0, `bus_err` 0, `wb_data` 0, `wb_rd` 0, `wb_reg_wr` 0.
  - Combinational outputs follow the inputs; EX/MEM resets to a NOP, so `dmem_req` = 0 and `mem_stall` = 0.
  - Reset mid-WAIT abandons the request; the memory must tolerate `req` dropping.
- **bus_err:** cleared only by reset.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- **Defined:**
  - Misaligned means LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]≠0`.
  - A misaligned access forces `dmem_req=0`, `dmem_we=0` and `mem_stall=0`.
  - It completes in one cycle with `wb_reg_wr <= 0`.
  - It pulses extra output `misalign_trap` (1 bit, registered, one cycle) and latches extra output `misalign_addr` (32 bits, reset 0).
- **Undefined:** those ports are absent and behaviour is as in the base build.

Test Plan:
- **Zero-wait LW:** addr 0x100, ready=1 at req, rdata 0xDEADBEEF → no stall; next cycle `wb_data`=0xDEADBEEF, `wb_reg_wr`=1.
- **LB/LBU:** addr 0x103, rdata 0x80FF_0000 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- **SB with 2 wait states:** addr 0x202, rv1 0x12345678, ready on 3rd cycle → `dmem_we`=0100, `wdata`=0x78787878 held for 3 cycles; `mem_stall`=1,1,0; two wb bubbles.
- **Timeout (TIMEOUT=4):** load, ready never asserted → 4 WAIT cycles then stall drops, `wb_reg_wr`=0, `bus_err`=1 until reset.
- **Non-memory op:** sel=10, pc_imm 0x400 → `dmem_req`=0; `wb_data`=0x400 one cycle later.
- **Reset asserted during WAIT** → next edge state IDLE, all wb outputs 0, `bus_err` 0.
